// File: rtl/key_event_fifo.sv
// Buffers hps_io PS/2 key events in a small FIFO and replays them as
// key_ready strobes separated by a fixed gap, with an optional typematic filter.
module key_event_fifo #(
  parameter int DEPTH       = 8,
  parameter int GAP_CYCLES  = 1024,
  parameter int DROP_REPEAT = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        clear_ovf,
  output logic        key_ready,
  output logic        key_stroke,
  output logic [9:0]  key_code,
  output logic [4:0]  fifo_count,
  output logic        overflow
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [4:0]    DEPTH_C  = 5'(DEPTH);
  localparam logic [15:0]   GAP_LOAD = 16'(GAP_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  // input sampling and event detection
  logic          tog_q, tog_prev_q;
  logic [1:0]    seed_q;
  logic [9:0]    samp_q;
  logic          det_s;
  // detected entry, pushed one cycle later
  logic          ev_q, ent_stroke_q;
  logic [9:0]    ent_code_q;
  // FIFO and bookkeeping
  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          rep_valid_q, rep_valid_d;
  logic [9:0]    rep_code_q, rep_code_d;
  logic          is_repeat_s, full_s, pop_s, push_s, ovf_evt_s;
  // pop FSM
  state_t        state_q, state_d;
  logic [15:0]   gap_q, gap_d;
  logic          key_ready_q, key_ready_d;
  logic          key_stroke_q, key_stroke_d;
  logic [9:0]    key_code_q, key_code_d;

  // seed_q[1] marks that tog_prev_q holds a real sample, so reset never fakes a toggle
  assign det_s = seed_q[1] & (tog_q ^ tog_prev_q);

  // Sample the key word and register detected events
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q        <= 1'b0;
      tog_prev_q   <= 1'b0;
      seed_q       <= 2'b00;
      samp_q       <= 10'd0;
      ev_q         <= 1'b0;
      ent_stroke_q <= 1'b0;
      ent_code_q   <= 10'd0;
    end else begin
      tog_q        <= ps2_key[10];
      tog_prev_q   <= tog_q;
      seed_q       <= {seed_q[0], 1'b1};
      samp_q       <= ps2_key[9:0];
      ev_q         <= det_s;
      ent_stroke_q <= samp_q[9];
      ent_code_q   <= {1'b0, samp_q[8:0]};
    end
  end

  // Push/pop arbitration, typematic filter and overflow flag
  always_comb begin
    full_s      = (count_q == DEPTH_C);
    pop_s       = (state_q == S_IDLE) && (count_q != 5'd0);
    is_repeat_s = (DROP_REPEAT != 0) && ev_q && ent_stroke_q && rep_valid_q &&
                  (rep_code_q == ent_code_q);
    push_s      = ev_q && !is_repeat_s && (!full_s || pop_s);
    ovf_evt_s   = ev_q && !is_repeat_s && full_s && !pop_s;

    wr_ptr_d    = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d    = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    rep_valid_d = rep_valid_q;
    rep_code_d  = rep_code_q;
    if (ev_q && !ent_stroke_q) begin
      rep_valid_d = 1'b0;
    end else if (push_s && ent_stroke_q) begin
      rep_valid_d = 1'b1;
      rep_code_d  = ent_code_q;
    end else begin
      rep_valid_d = rep_valid_q;
    end

    // a new loss outranks a coincident clear
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pop FSM: one-cycle strobe then a counted gap
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    key_stroke_d = key_stroke_q;
    key_code_d   = key_code_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          state_d      = S_PRESENT;
          key_stroke_d = mem_q[rd_ptr_q][10];
          key_code_d   = mem_q[rd_ptr_q][9:0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESENT: begin
        if (GAP_CYCLES <= 2) begin
          state_d = S_IDLE;
          gap_d   = 16'd0;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q <= 16'd1) begin
          state_d = S_IDLE;
          gap_d   = 16'd0;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gap_d   = 16'd0;
      end
    endcase
    key_ready_d = (state_d == S_PRESENT);
  end

  // FIFO storage is intentionally not reset
  always_ff @(posedge clk_sys) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {ent_stroke_q, ent_code_q};
    end
  end

  // State and output registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= 5'd0;
      ovf_q        <= 1'b0;
      rep_valid_q  <= 1'b0;
      rep_code_q   <= 10'd0;
      state_q      <= S_IDLE;
      gap_q        <= 16'd0;
      key_ready_q  <= 1'b0;
      key_stroke_q <= 1'b0;
      key_code_q   <= 10'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      rep_valid_q  <= rep_valid_d;
      rep_code_q   <= rep_code_d;
      state_q      <= state_d;
      gap_q        <= gap_d;
      key_ready_q  <= key_ready_d;
      key_stroke_q <= key_stroke_d;
      key_code_q   <= key_code_d;
    end
  end

  assign key_ready  = key_ready_q;
  assign key_stroke = key_stroke_q;
  assign key_code   = key_code_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Scoreboard bench for key_event_fifo: stimulus queues expected strobes,
// a forked monitor pops and compares them whenever key_ready is seen.
module tb_key_event_fifo;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [10:0] ps2_key = 11'd0;
  logic        key_ready, key_stroke, overflow;
  logic [9:0]  key_code;
  logic [4:0]  fifo_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_str = 0;
  int strobe_t [0:127];
  logic [10:0] exp_q [$];

  key_event_fifo #(.DEPTH(8), .GAP_CYCLES(16), .DROP_REPEAT(1)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .clear_ovf (clear_ovf),
    .key_ready (key_ready),
    .key_stroke(key_stroke),
    .key_code  (key_code),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk_sys);
      if (reset_n && key_ready) begin
        if (n_str < 128) strobe_t[n_str] = cyc;
        n_str++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got code 0x%0h stroke %0d, required no strobe",
                   key_code, key_stroke);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("strobe_event", {21'd0, key_stroke, key_code}, {21'd0, e});
        end
      end
    end
  endtask

  task automatic send(input logic pressed, input logic [8:0] code, output int t);
    @(posedge clk_sys);
    #1;
    ps2_key = {~ps2_key[10], pressed, code};
    t = cyc;
  endtask

  task automatic expect_ev(input logic pressed, input logic [8:0] code);
    exp_q.push_back({pressed, 1'b0, code});
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk_sys);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int t0, base, peak;
    fork
      monitor();
    join_none

    // reset values
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_key_ready", key_ready, 0);
    check("rst_key_stroke", key_stroke, 0);
    check("rst_key_code", key_code, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk_sys) reset_n = 1'b1;
    repeat (4) @(posedge clk_sys);

    // single press: strobe 4 cycle-counts after the drive point
    base = n_str;
    expect_ev(1'b1, 9'h01C);
    send(1'b1, 9'h01C, t0);
    drain(50);
    check("single_latency", strobe_t[base], t0 + 4);
    repeat (20) @(negedge clk_sys);
    check("single_count_idle", fifo_count, 0);

    // burst of five in consecutive cycles
    base = n_str;
    for (int i = 0; i < 5; i++) begin
      expect_ev(1'b1, 9'(9'h021 + i));
      send(1'b1, 9'(9'h021 + i), t0);
    end
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    drain(200);
    for (int i = 1; i < 5; i++) check("burst_spacing", strobe_t[base+i] - strobe_t[base+i-1], 16);
    check("burst_peak_4_or_5", (peak >= 4 && peak <= 5) ? 1 : 0, 1);
    repeat (20) @(negedge clk_sys);

    // typematic: make x3, break, make
    base = n_str;
    expect_ev(1'b1, 9'h11C);
    expect_ev(1'b0, 9'h11C);
    expect_ev(1'b1, 9'h11C);
    for (int i = 0; i < 3; i++) send(1'b1, 9'h11C, t0);
    send(1'b0, 9'h11C, t0);
    send(1'b1, 9'h11C, t0);
    drain(200);
    repeat (40) @(negedge clk_sys);
    check("typematic_strobes", n_str - base, 3);

    // overflow: 12 back-to-back, 1 in flight + 8 buffered survive
    base = n_str;
    for (int i = 0; i < 12; i++) begin
      if (i < 9) expect_ev(1'b1, 9'(9'h030 + i));
      send(1'b1, 9'(9'h030 + i), t0);
    end
    repeat (5) @(negedge clk_sys);
    check("ovf_count_full", fifo_count, 8);
    check("ovf_set", overflow, 1);
    drain(400);
    repeat (40) @(negedge clk_sys);
    check("ovf_delivered", n_str - base, 9);
    check("ovf_sticky", overflow, 1);
    @(posedge clk_sys); #1 clear_ovf = 1'b1;
    @(posedge clk_sys); #1 clear_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // reset mid-GAP with three entries buffered
    base = n_str;
    expect_ev(1'b1, 9'h040);
    for (int i = 0; i < 4; i++) send(1'b1, 9'(9'h040 + i), t0);
    drain(50);
    repeat (3) @(negedge clk_sys);
    check("gap_buffered", fifo_count, 3);
    #2 reset_n = 1'b0;
    #1;
    check("abort_count", fifo_count, 0);
    check("abort_key_ready", key_ready, 0);
    check("abort_key_code", key_code, 0);
    @(negedge clk_sys) reset_n = 1'b1;
    repeat (40) @(negedge clk_sys);
    check("abort_no_strobe", n_str - base, 1);

    // reset release with toggle steady high
    base = n_str;
    reset_n = 1'b0;
    ps2_key = {1'b1, 1'b1, 9'h05A};
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (40) @(negedge clk_sys);
    check("seed_no_strobe", n_str - base, 0);
    check("seed_count", fifo_count, 0);

    // a real toggle afterwards still gets through
    expect_ev(1'b0, 9'h05A);
    send(1'b0, 9'h05A, t0);
    drain(50);
    check("recover_strobes", n_str - base, 1);

    repeat (5) @(negedge clk_sys);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
